// File: rtl/ccl_fetch_redirect_if.sv
// Bundle of the fetch unit's CCLU, instruction-memory, decode and trap signals.
// master: the fetch/redirect unit itself; slave: its surrounding environment.
interface ccl_fetch_redirect_if;
  // CCLU side
  logic        ccl_valid;
  logic [31:0] ccl_target;
  logic        ccl_full;
  logic        ccl_error;
  // instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // decode side
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        flush;
  // trap side
  logic        trap;
  logic [31:0] trap_pc;
  logic        trap_clear;

  modport master (
    input  ccl_valid, ccl_target, ccl_full, ccl_error,
    input  imem_ack, imem_rdata, instr_ready, trap_clear,
    output imem_req, imem_addr, instr_valid, instr, instr_pc, flush, trap, trap_pc
  );

  modport slave (
    output ccl_valid, ccl_target, ccl_full, ccl_error,
    output imem_ack, imem_rdata, instr_ready, trap_clear,
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, flush, trap, trap_pc
  );
endinterface

// File: rtl/ccl_fetch_redirect.sv
// Fetch-side PC unit downstream of the counted-loop unit (CCLU).
// Keeps one instruction fetch in flight at most, buffers the fetched word in
// a single valid/ready entry for decode, and reacts to CCLU redirects, errors
// and stack-full back-pressure. All outputs come straight from registers.
module ccl_fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic                  i_clock,
  input logic                  i_reset,
  ccl_fetch_redirect_if.master bus
);

  // FETCH: idle, may issue. WAIT: request outstanding, data kept.
  // DRAIN: request outstanding, data dropped. TRAP: halted until trap_clear.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_flush;
  logic        r_trap;
  logic [31:0] r_trap_pc;

  logic        w_ack;
  logic        w_consume;
  logic        w_err;
  logic        w_redir;
  logic        w_issue;

  // Classify this cycle's events; error (incl. misaligned target) outranks redirect, which outranks ack.
  always_comb begin
    w_ack     = r_imem_req & bus.imem_ack;
    w_consume = r_instr_valid & bus.instr_ready;
    if (r_state == ST_TRAP) begin
      w_err   = 1'b0;
      w_redir = 1'b0;
    end else begin
      w_err   = bus.ccl_error | (bus.ccl_valid & (bus.ccl_target[1:0] != 2'b00));
      w_redir = bus.ccl_valid & ~w_err;
    end
    w_issue = (r_state == ST_FETCH) & ~w_err & ~w_redir & ~bus.ccl_full
            & (~r_instr_valid | bus.instr_ready);
  end

  // Main state, PC, fetch handshake, decode buffer and trap registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_flush       <= 1'b0;
      r_trap        <= 1'b0;
      r_trap_pc     <= 32'h0000_0000;
    end else begin
      r_flush <= 1'b0;
      // A decode transfer always completes, even alongside a redirect or trap.
      if (w_consume) begin
        r_instr_valid <= 1'b0;
      end
      if (w_err) begin
        // Trap entry: report the oldest live PC; any outstanding fetch keeps draining.
        r_trap_pc     <= r_instr_valid ? r_instr_pc : r_pc;
        r_trap        <= 1'b1;
        r_instr_valid <= 1'b0;
        r_flush       <= 1'b1;
        r_state       <= ST_TRAP;
        if (w_ack) begin
          r_imem_req <= 1'b0;
        end
      end else if (w_redir) begin
        r_pc          <= bus.ccl_target;
        r_instr_valid <= 1'b0;
        r_flush       <= 1'b1;
        // An ack landing with the redirect is simply discarded.
        if (r_imem_req & ~w_ack) begin
          r_state <= ST_DRAIN;
        end else begin
          r_imem_req <= 1'b0;
          r_state    <= ST_FETCH;
        end
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (w_issue) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
              r_state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (w_ack) begin
              r_imem_req    <= 1'b0;
              r_instr       <= bus.imem_rdata;
              r_instr_pc    <= r_pc;
              r_pc          <= r_pc + PC_STEP;
              r_instr_valid <= 1'b1;
              r_state       <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (w_ack) begin
              r_imem_req <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
          ST_TRAP: begin
            if (w_ack) begin
              r_imem_req <= 1'b0;
            end
            if (bus.trap_clear) begin
              r_trap <= 1'b0;
              r_pc   <= RESET_PC;
              // A fetch still in flight from before the trap must be dropped.
              r_state <= (r_imem_req & ~w_ack) ? ST_DRAIN : ST_FETCH;
            end
          end
          default: begin
            r_state <= ST_FETCH;
          end
        endcase
      end
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.flush       = r_flush;
  assign bus.trap        = r_trap;
  assign bus.trap_pc     = r_trap_pc;

endmodule

// File: tb/tb_ccl_fetch_redirect.sv
// Bench for ccl_fetch_redirect: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ccl_fetch_redirect;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccl_fetch_redirect_if bus ();

  ccl_fetch_redirect #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int ack_mode     = 0;   // 0 never, 1 whenever a fetch is pending, 2 random, 3 always

  // Reference model: what the unit should be showing right now.
  logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_trap_pc;
  logic        m_req, m_discard, m_ivalid, m_flush, m_trap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_addr = RESET_PC; m_instr = 32'd0; m_ipc = 32'd0; m_trap_pc = 32'd0;
    m_req = 1'b0; m_discard = 1'b0; m_ivalid = 1'b0; m_flush = 1'b0; m_trap = 1'b0;
  endtask

  // Apply the rules for one rising edge, using the inputs currently driven.
  task automatic model_edge();
    logic ack_eff, err, can_issue;
    ack_eff = m_req & bus.imem_ack;
    m_flush = 1'b0;
    if (m_trap) begin
      if (ack_eff) m_req = 1'b0;
      if (bus.trap_clear) begin
        m_trap = 1'b0;
        m_pc = RESET_PC;
        m_discard = m_req;
      end
    end else begin
      err = bus.ccl_error | (bus.ccl_valid & (bus.ccl_target[1:0] != 2'b00));
      if (err) begin
        m_trap_pc = m_ivalid ? m_ipc : m_pc;
        m_trap = 1'b1; m_ivalid = 1'b0; m_flush = 1'b1;
        if (ack_eff) m_req = 1'b0;
      end else if (bus.ccl_valid) begin
        m_pc = bus.ccl_target; m_ivalid = 1'b0; m_flush = 1'b1;
        if (m_req && !ack_eff) m_discard = 1'b1;
        else m_req = 1'b0;
      end else begin
        can_issue = !m_req && !bus.ccl_full && (!m_ivalid || bus.instr_ready);
        if (m_ivalid && bus.instr_ready) m_ivalid = 1'b0;
        if (ack_eff) begin
          m_req = 1'b0;
          if (!m_discard) begin
            m_instr = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + PC_STEP; m_ivalid = 1'b1;
          end
        end else if (can_issue) begin
          m_req = 1'b1; m_addr = m_pc; m_discard = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("imem_req",    32'(bus.imem_req),    32'(m_req));
    check_eq("imem_addr",   bus.imem_addr,        m_addr);
    check_eq("instr_valid", 32'(bus.instr_valid), 32'(m_ivalid));
    if (m_ivalid) begin
      check_eq("instr",    bus.instr,    m_instr);
      check_eq("instr_pc", bus.instr_pc, m_ipc);
    end
    check_eq("flush", 32'(bus.flush), 32'(m_flush));
    check_eq("trap",  32'(bus.trap),  32'(m_trap));
    if (m_trap) check_eq("trap_pc", bus.trap_pc, m_trap_pc);
  endtask

  task automatic check_reset_values();
    check_eq("rst_imem_req",    32'(bus.imem_req),    32'd0);
    check_eq("rst_imem_addr",   bus.imem_addr,        RESET_PC);
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr",       bus.instr,            32'd0);
    check_eq("rst_instr_pc",    bus.instr_pc,         32'd0);
    check_eq("rst_flush",       32'(bus.flush),       32'd0);
    check_eq("rst_trap",        32'(bus.trap),        32'd0);
    check_eq("rst_trap_pc",     bus.trap_pc,          32'd0);
  endtask

  task automatic set_idle();
    bus.ccl_valid = 1'b0; bus.ccl_target = 32'd0; bus.ccl_full = 1'b0;
    bus.ccl_error = 1'b0; bus.instr_ready = 1'b1; bus.trap_clear = 1'b0;
  endtask

  // One clock: pick the memory response, let the edge happen, then compare.
  task automatic step();
    case (ack_mode)
      0:       bus.imem_ack = 1'b0;
      1:       bus.imem_ack = m_req;
      2:       bus.imem_ack = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      default: bus.imem_ack = 1'b1;
    endcase
    bus.imem_rdata = $urandom();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Sequential fetches 0,4,8,C with prompt acks and decode always ready.
    ack_mode = 1;
    step_n(8);

    // Decode stalls with the buffer full: no fetch, buffer stable.
    bus.instr_ready = 1'b0;
    step_n(5);
    bus.instr_ready = 1'b1;

    // Fetch to 0x10 left outstanding, then a redirect to 0x100 drops it.
    ack_mode = 0;
    step_n(2);
    check_eq("req_0x10_pending", 32'(bus.imem_req), 32'd1);
    bus.ccl_valid = 1'b1; bus.ccl_target = 32'h0000_0100;
    step();
    bus.ccl_valid = 1'b0;
    ack_mode = 1;
    step_n(4);

    // Buffer 0x20, then error together with a redirect traps on 0x20.
    bus.ccl_valid = 1'b1; bus.ccl_target = 32'h0000_0020;
    step();
    bus.ccl_valid = 1'b0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 10 && !(m_ivalid && m_ipc == 32'h0000_0020); i++) step();
    check_eq("buffered_0x20", bus.instr_pc, 32'h0000_0020);
    bus.ccl_error = 1'b1; bus.ccl_valid = 1'b1; bus.ccl_target = 32'h0000_0040;
    step();
    bus.ccl_error = 1'b0; bus.ccl_valid = 1'b0;
    step_n(3);
    bus.trap_clear = 1'b1;
    step();
    bus.trap_clear = 1'b0;
    bus.instr_ready = 1'b1;
    step_n(3);

    // Misaligned redirect target traps.
    bus.ccl_valid = 1'b1; bus.ccl_target = 32'h0000_0102;
    step();
    bus.ccl_valid = 1'b0;
    step_n(2);
    bus.trap_clear = 1'b1;
    step();
    bus.trap_clear = 1'b0;

    // PC wraps past the top of the address space.
    bus.ccl_valid = 1'b1; bus.ccl_target = 32'hFFFF_FFFC;
    step();
    bus.ccl_valid = 1'b0;
    step_n(6);

    // CCLU stack full for three cycles holds new fetches.
    bus.ccl_full = 1'b1;
    step_n(3);
    bus.ccl_full = 1'b0;
    step_n(3);

    // Asynchronous reset in the middle of an outstanding fetch, then a late ack.
    ack_mode = 0;
    for (int i = 0; i < 10 && !m_req; i++) step();
    check_eq("req_before_reset", 32'(bus.imem_req), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ack_mode = 3;
    step();
    ack_mode = 1;
    step_n(4);

    // Random traffic.
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      bus.ccl_valid  = ($urandom_range(0, 15) == 0);
      bus.ccl_target = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) bus.ccl_target = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C);
      if ($urandom_range(0, 7) == 0) bus.ccl_target[1:0] = 2'($urandom_range(1, 3));
      bus.ccl_error   = ($urandom_range(0, 63) == 0);
      bus.ccl_full    = ($urandom_range(0, 3) == 0);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.trap_clear  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
